reg_dump: RTL and testbench

REG_DUMP -- requirements
Module: reg_dump

---
 rtl/reg_dump.sv | 97 +++++++++
 tb/tb_reg_dump.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump.sv
// Register-file dump engine: walks the read port from FIRST to LAST (wrapping mod 8)
// and streams each byte over a valid/ready handshake while summing accepted bytes.
module reg_dump #(
  parameter int unsigned READ_WAIT = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [2:0] FIRST,
  input  logic [2:0] LAST,
  output logic [2:0] RDADDRESS,
  input  logic [7:0] RDDATA,
  output logic [7:0] DOUT,
  output logic       DVALID,
  input  logic       DREADY,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] CHECKSUM
);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, SEND, FIN} state_t;

  localparam logic [1:0] WAIT_LOAD = 2'(READ_WAIT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] wait_cnt;
  logic [2:0] last_addr;
  logic       xfer;

  assign xfer = (state == SEND) && DVALID && DREADY;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = ADDR;
      ADDR:    state_nxt = WAIT;
      WAIT:    if (wait_cnt == '0) state_nxt = SEND;
      SEND:    if (xfer) state_nxt = (RDADDRESS == last_addr) ? FIN : ADDR;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // DOUT is captured once in WAIT so later read-port changes cannot disturb a held byte.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      RDADDRESS <= '0;
      last_addr <= '0;
      wait_cnt  <= '0;
      DOUT      <= '0;
      DVALID    <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      CHECKSUM  <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            RDADDRESS <= FIRST;
            last_addr <= LAST;
            CHECKSUM  <= '0;
            BUSY      <= 1'b1;
          end
        end
        ADDR: wait_cnt <= WAIT_LOAD;
        WAIT: begin
          if (wait_cnt == '0) begin
            DOUT   <= RDDATA;
            DVALID <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        SEND: begin
          if (xfer) begin
            CHECKSUM <= CHECKSUM + DOUT;
            DVALID   <= 1'b0;
            if (RDADDRESS != last_addr) RDADDRESS <= RDADDRESS + 3'd1;
          end
        end
        FIN: begin
          DONE <= 1'b1;
          BUSY <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump.sv
// Scoreboard bench for reg_dump: expected (address, byte) pairs are queued at each START
// and retired by a monitor on every accepted transfer; checksum and DONE checked at dump end.
module tb_reg_dump;

  localparam int unsigned RW = 1;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start3;
  logic [2:0] first, last, first3, last3;
  logic [2:0] rdaddress, rdaddress3;
  logic [7:0] rddata, rddata3;
  logic [7:0] dout, dout3;
  logic       dvalid, dvalid3;
  logic       dready, dready3;
  logic       busy, busy3;
  logic       done, done3;
  logic [7:0] checksum, checksum3;

  logic [7:0] regs [8];

  exp_t       q[$];
  logic [7:0] exp_chk;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         ref_cyc = 0;
  int         last_xfer = 0;
  int         xfers = 0;
  int         done_cnt = 0;
  logic       prev_dvalid = 1'b0;
  logic       prev_done = 1'b0;

  assign rddata  = regs[rdaddress];
  assign rddata3 = regs[rdaddress3];

  reg_dump #(.READ_WAIT(RW)) dut (
    .CLK(clk), .RESET(rst), .START(start), .FIRST(first), .LAST(last),
    .RDADDRESS(rdaddress), .RDDATA(rddata), .DOUT(dout), .DVALID(dvalid),
    .DREADY(dready), .BUSY(busy), .DONE(done), .CHECKSUM(checksum)
  );

  reg_dump #(.READ_WAIT(3)) dut3 (
    .CLK(clk), .RESET(rst), .START(start3), .FIRST(first3), .LAST(last3),
    .RDADDRESS(rdaddress3), .RDDATA(rddata3), .DOUT(dout3), .DVALID(dvalid3),
    .DREADY(dready3), .BUSY(busy3), .DONE(done3), .CHECKSUM(checksum3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input logic [2:0] f, input logic [2:0] l);
    logic [2:0] span;
    exp_t       e;
    span    = l - f;
    exp_chk = '0;
    for (int i = 0; i <= int'(span); i++) begin
      e.addr  = f + 3'(i);
      e.data  = regs[e.addr];
      exp_chk = exp_chk + e.data;
      q.push_back(e);
    end
  endtask

  task automatic run(input logic [2:0] f, input logic [2:0] l);
    push_range(f, l);
    first = f;
    last  = l;
    start = 1'b1;
    tick();
    start   = 1'b0;
    ref_cyc = cyc;
    check("busy_on_start", busy, 1);
    check("addr_on_start", rdaddress, f);
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt != d0) break;
    end
    check("done_seen", done_cnt - d0, 1);
  endtask

  task automatic wait_xfers(input int target);
    for (int i = 0; i < 40; i++) begin
      if (xfers >= target) break;
      tick();
    end
    check("xfer_reached", xfers >= target, 1);
  endtask

  task automatic wait_dvalid();
    for (int i = 0; i < 10; i++) begin
      if (dvalid) break;
      tick();
    end
    check("dvalid_reached", dvalid, 1);
  endtask

  // Scoreboard monitor: samples on the falling edge, transfers complete on the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (dvalid && !prev_dvalid) check("dvalid_latency", cyc - ref_cyc, RW + 1);
      if (dvalid && dready) begin
        check("q_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          check("xfer_addr", rdaddress, e.addr);
          check("xfer_dout", dout, e.data);
        end
        xfers++;
        ref_cyc   = cyc + 1;
        last_xfer = cyc + 1;
      end
      if (done) begin
        done_cnt++;
        check("done_single", prev_done, 0);
        check("done_after_xfer", cyc - last_xfer, 1);
        check("checksum_end", checksum, exp_chk);
        check("q_drained", q.size(), 0);
        check("busy_at_done", busy, 0);
      end
      prev_dvalid = dvalid;
      prev_done   = done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int x0;
    int d0;
    for (int i = 0; i < 8; i++) regs[i] = 8'((i + 1) * 10);
    rst = 1'b1; start = 1'b0; first = '0; last = '0; dready = 1'b1;
    start3 = 1'b0; first3 = '0; last3 = '0; dready3 = 1'b1;

    #12;
    check("reset_outs", {rdaddress, dout, dvalid, busy, done, checksum}, 0);
    check("reset_outs3", {rdaddress3, dout3, dvalid3, busy3, done3, checksum3}, 0);

    // START held across reset release is taken at the first edge
    push_range(3'd5, 3'd5);
    first = 3'd5; last = 3'd5; start = 1'b1;
    #1 rst = 1'b0;
    tick();
    start   = 1'b0;
    ref_cyc = cyc;
    check("start_thru_reset_busy", busy, 1);
    check("start_thru_reset_addr", rdaddress, 5);
    wait_done(20);
    check("chk_single5", checksum, 60);

    run(3'd0, 3'd7);
    wait_done(60);
    check("chk_full", checksum, 104);
    repeat (3) tick();
    check("chk_hold_idle", checksum, 104);
    check("busy_idle", busy, 0);

    run(3'd6, 3'd1);
    wait_done(60);
    check("chk_wrap", checksum, 180);

    run(3'd3, 3'd3);
    wait_done(20);
    check("chk_one", checksum, 40);
    tick();
    check("busy_after_one", busy, 0);

    // Back-pressure on byte 2 while the register behind it changes
    x0 = xfers;
    run(3'd0, 3'd7);
    wait_xfers(x0 + 1);
    dready = 1'b0;
    wait_dvalid();
    regs[1] = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      check("stall_dout", dout, 20);
      check("stall_dvalid", dvalid, 1);
      check("stall_addr", rdaddress, 1);
      check("stall_chk", checksum, 10);
      tick();
    end
    regs[1] = 8'd20;
    dready  = 1'b1;
    wait_done(60);
    check("chk_stall", checksum, 104);

    // Asynchronous reset mid-dump during byte 3
    x0 = xfers;
    run(3'd0, 3'd7);
    wait_xfers(x0 + 2);
    wait_dvalid();
    #3 rst = 1'b1;
    #1;
    check("async_reset_outs", {rdaddress, dout, dvalid, busy, done, checksum}, 0);
    d0 = done_cnt;
    q.delete();
    #3 rst = 1'b0;
    repeat (4) tick();
    check("idle_after_reset_busy", busy, 0);
    check("idle_after_reset_dvalid", dvalid, 0);
    check("no_done_after_abort", done_cnt - d0, 0);
    run(3'd0, 3'd7);
    wait_done(60);
    check("chk_after_reset", checksum, 104);

    // START while busy must not re-capture the range
    run(3'd2, 3'd5);
    tick();
    first = 3'd0; last = 3'd7; start = 1'b1;
    tick();
    start = 1'b0;
    check("ignored_start_busy", busy, 1);
    check("ignored_start_addr", rdaddress, 2);
    wait_done(60);
    check("chk_ignored_start", checksum, 180);

    // READ_WAIT=3 latency
    first3 = 3'd4; last3 = 3'd4; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (k = 1; k <= 10; k++) begin
      tick();
      if (dvalid3) break;
    end
    check("rw3_latency", k, 4);
    check("rw3_dout", dout3, 50);
    tick();
    tick();
    check("rw3_done", done3, 1);
    check("rw3_chk", checksum3, 50);
    check("rw3_busy", busy3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
